// File: rtl/phy_rx_align_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// phy_rx_align_ctrl_pkg
// Shared PHY definitions for the receive-path word aligner. Also usable by the
// TX idle generator.
//   COMMA_SYM          idle / alignment symbol (K28.5 style 0xBC)
//   *_DEF              default tuning values for the alignment controller
//   align_state_e      controller state encoding
//   rol8               rotate a byte left by 0..7 bits
//   is_rotated_symbol  byte equals a symbol rotated by 1..7 bits, but not the
//                      symbol itself
// ---------------------------------------------------------------------------
package phy_rx_align_ctrl_pkg;

   localparam logic [7:0] COMMA_SYM      = 8'hBC;
   localparam int         LOCK_CNT_DEF   = 4;
   localparam int         SEARCH_WIN_DEF = 16;
   localparam int         SLIP_WAIT_DEF  = 3;
   localparam int         LOSS_CNT_DEF   = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SETTLE = 2'd1,
      COUNT  = 2'd2,
      ACTIVE = 2'd3
   } align_state_e;

   // Rotating a doubled copy keeps the bits that wrap off the top.
   function automatic logic [7:0] rol8(input logic [7:0] value,
                                       input logic [2:0] amount);
      logic [15:0] doubled;
      doubled = {value, value} << amount;
      return doubled[15:8];
   endfunction

   // A symbol whose rotation happens to equal itself never counts as rotated.
   function automatic logic is_rotated_symbol(input logic [7:0] value,
                                              input logic [7:0] symbol);
      logic hit;
      hit = 1'b0;
      for (int k = 1; k < 8; k++) begin
         if ((rol8(symbol, 3'(k)) == value) && (value != symbol)) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/phy_rx_align_ctrl_comma_detect.sv
// ---------------------------------------------------------------------------
// phy_comma_detect
// Combinational comma classifier for one raw deserializer byte.
//   byte_in       in   8  raw byte
//   is_comma      out  1  byte is exactly the comma symbol
//   is_rot_comma  out  1  byte is the comma rotated by 1..7 bits
// ---------------------------------------------------------------------------
module phy_comma_detect
   import phy_rx_align_ctrl_pkg::*;
#(
   parameter logic [7:0] COMMA = COMMA_SYM
) (
   input  logic [7:0] byte_in,
   output logic       is_comma,
   output logic       is_rot_comma
);

   assign is_comma     = (byte_in == COMMA);
   assign is_rot_comma = is_rotated_symbol(byte_in, COMMA);

endmodule

// File: rtl/phy_rx_align_ctrl.sv
// ---------------------------------------------------------------------------
// phy_rx_align_ctrl
// Word-alignment and link-training controller for the PHY receive path.
// Hunts for the idle comma, pulses bitslip to walk the deserializer phase,
// declares the link active after a run of aligned commas and then forwards
// payload bytes. Repeated misaligned commas drop the link back to search.
//   clk_4f        in   1  byte clock
//   reset_L       in   1  asynchronous active-low reset
//   byte_in       in   8  raw byte from the deserializer
//   bitslip_out   out  1  one-cycle pulse asking the deserializer to slip
//   data_out      out  8  aligned byte to the link layer
//   valid_out     out  1  data_out holds payload (non-comma while active)
//   active_out    out  1  link locked
//   slip_cnt_out  out  3  bitslips issued since reset, modulo 8
// ---------------------------------------------------------------------------
module phy_rx_align_ctrl
   import phy_rx_align_ctrl_pkg::*;
#(
   parameter logic [7:0] COMMA      = COMMA_SYM,
   parameter int         LOCK_CNT   = LOCK_CNT_DEF,
   parameter int         SEARCH_WIN = SEARCH_WIN_DEF,
   parameter int         SLIP_WAIT  = SLIP_WAIT_DEF,
   parameter int         LOSS_CNT   = LOSS_CNT_DEF
) (
   input  logic       clk_4f,
   input  logic       reset_L,
   input  logic [7:0] byte_in,
   output logic       bitslip_out,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active_out,
   output logic [2:0] slip_cnt_out
);

   localparam logic [7:0] MISS_LAST   = 8'(SEARCH_WIN - 1);
   localparam logic [3:0] WAIT_LAST   = 4'(SLIP_WAIT - 1);
   localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_TARGET = 4'(LOSS_CNT);

   align_state_e state, state_next;
   logic [7:0]   miss_cnt, miss_next;
   logic [3:0]   wait_cnt, wait_next;
   logic [3:0]   lock_cnt, lock_next;
   logic [3:0]   err_cnt, err_next;
   logic [3:0]   err_bump;
   logic [2:0]   slip_next;
   logic [7:0]   data_next;
   logic         valid_next;
   logic         active_next;
   logic         bitslip_next;
   logic         is_comma;
   logic         is_rot_comma;

   phy_comma_detect #(
      .COMMA (COMMA)
   ) u_comma_detect (
      .byte_in      (byte_in),
      .is_comma     (is_comma),
      .is_rot_comma (is_rot_comma)
   );

   // State, counters and every output are registered together so that all
   // outputs change on the same clk_4f edge and reset clears them at once.
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         state        <= SEARCH;
         miss_cnt     <= '0;
         wait_cnt     <= '0;
         lock_cnt     <= '0;
         err_cnt      <= '0;
         slip_cnt_out <= '0;
         data_out     <= '0;
         valid_out    <= 1'b0;
         active_out   <= 1'b0;
         bitslip_out  <= 1'b0;
      end else begin
         state        <= state_next;
         miss_cnt     <= miss_next;
         wait_cnt     <= wait_next;
         lock_cnt     <= lock_next;
         err_cnt      <= err_next;
         slip_cnt_out <= slip_next;
         data_out     <= data_next;
         valid_out    <= valid_next;
         active_out   <= active_next;
         bitslip_out  <= bitslip_next;
      end
   end

   // Error count as it would stand after the current byte while locked:
   // an aligned comma forgives everything, a rotated comma adds one
   // (saturating), anything else is neutral payload.
   always_comb begin
      err_bump = err_cnt;
      if (is_comma) begin
         err_bump = '0;
      end else if (is_rot_comma && (err_cnt != LOSS_TARGET)) begin
         err_bump = err_cnt + 4'd1;
      end
   end

   // Next-state and next-output logic. Outside ACTIVE the data register
   // simply holds and valid stays low. The bitslip pulse is only ever
   // requested on the way into SETTLE, which lasts at least one cycle, so
   // two slips can never be back to back.
   always_comb begin
      state_next   = state;
      miss_next    = miss_cnt;
      wait_next    = wait_cnt;
      lock_next    = lock_cnt;
      err_next     = err_cnt;
      slip_next    = slip_cnt_out;
      data_next    = data_out;
      valid_next   = 1'b0;
      bitslip_next = 1'b0;

      case (state)
         SEARCH: begin
            if (is_comma) begin
               miss_next = '0;
               if (LOCK_CNT == 1) begin
                  state_next = ACTIVE;
                  lock_next  = '0;
                  err_next   = '0;
               end else begin
                  state_next = COUNT;
                  lock_next  = 4'd1;
               end
            end else if (miss_cnt == MISS_LAST) begin
               bitslip_next = 1'b1;
               slip_next    = slip_cnt_out + 3'd1;
               miss_next    = '0;
               wait_next    = '0;
               state_next   = SETTLE;
            end else begin
               miss_next = miss_cnt + 8'd1;
            end
         end

         SETTLE: begin
            if (wait_cnt == WAIT_LAST) begin
               wait_next  = '0;
               state_next = SEARCH;
            end else begin
               wait_next = wait_cnt + 4'd1;
            end
         end

         // A broken run returns to SEARCH without slipping: the phase that
         // produced the earlier commas is most likely still correct.
         COUNT: begin
            if (is_comma) begin
               if ((lock_cnt + 4'd1) == LOCK_TARGET) begin
                  state_next = ACTIVE;
                  lock_next  = '0;
                  err_next   = '0;
               end else begin
                  lock_next = lock_cnt + 4'd1;
               end
            end else begin
               state_next = SEARCH;
               lock_next  = '0;
               miss_next  = '0;
            end
         end

         // The byte that pushes the error count to the loss threshold is
         // dropped: valid falls and data_out keeps the previous byte.
         ACTIVE: begin
            if (err_bump == LOSS_TARGET) begin
               state_next = SEARCH;
               err_next   = '0;
               miss_next  = '0;
            end else begin
               err_next   = err_bump;
               data_next  = byte_in;
               valid_next = !is_comma;
            end
         end

         default: begin
            state_next = SEARCH;
         end
      endcase

      active_next = (state_next == ACTIVE);
   end

endmodule
